// File: rtl/sorted_insert_writer_if.sv
// Request and RAM-port bundle for sorted_insert_writer.
//   master : request side (start/A/clear) plus RAM read data (mem_q)
//   slave  : the writer; returns handshake status, occupancy and RAM controls
interface sorted_insert_writer_if #(
  parameter int unsigned VAL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  start;
  logic [VAL_WIDTH-1:0]  A;
  logic                  clear;
  logic                  ready;
  logic                  done;
  logic                  reject;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [VAL_WIDTH-1:0]  mem_data;
  logic                  mem_wren;
  logic [VAL_WIDTH-1:0]  mem_q;

  modport master (
    output start, A, clear, mem_q,
    input  ready, done, reject, count, mem_addr, mem_data, mem_wren
  );

  modport slave (
    input  start, A, clear, mem_q,
    output ready, done, reject, count, mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/sorted_insert_writer.sv
// Sorted-insert writer: keeps a single-port RAM holding an ascending array.
// Each accepted value is placed by scanning down from the top entry, moving
// larger entries up one slot, then writing the value into the gap.
// Ports:
//   clock   : system clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of sorted_insert_writer_if
//             start/A/clear in, ready/done/reject/count out,
//             mem_addr/mem_data/mem_wren out, mem_q in
// RAM controls are driven combinationally from state; the RAM registers
// them, and the shift write in S_CMP must forward mem_q in the same cycle.
module sorted_insert_writer #(
  parameter int unsigned VAL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset_n,
  sorted_insert_writer_if.slave  bus
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_PUT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [VAL_WIDTH-1:0]  a_q, a_d;
  logic [CNT_WIDTH-1:0]  i_q, i_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  reject_q, reject_d;

  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [VAL_WIDTH-1:0]  mem_data_c;
  logic                  mem_wren_c;

  logic                  shift_c;
  logic                  i_zero_c;
  logic                  full_c;

  // Entry under inspection is larger than the new value: it moves up.
  assign shift_c  = (bus.mem_q > a_q);
  assign i_zero_c = (i_q == '0);
  assign full_c   = (count_q == CAP);

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      i_q      <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      i_q      <= i_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      reject_q <= reject_d;
    end
  end

  // Next-state and datapath update; i holds the scan index, then the slot.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    i_d     = i_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          count_d = '0;
        end else if (bus.start && !full_c) begin
          a_d = bus.A;
          if (count_q == '0) begin
            i_d     = '0;
            state_d = S_PUT;
          end else begin
            i_d     = count_q - CNT_WIDTH'(1);
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        if (shift_c) begin
          if (i_zero_c) begin
            i_d     = '0;
            state_d = S_PUT;
          end else begin
            i_d     = i_q - CNT_WIDTH'(1);
            state_d = S_RD;
          end
        end else begin
          // Equal entries stop the scan, so duplicates stay in arrival order.
          i_d     = i_q + CNT_WIDTH'(1);
          state_d = S_PUT;
        end
      end
      S_PUT: begin
        count_d = count_q + CNT_WIDTH'(1);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM controls for the current state and next values of the status flags.
  always_comb begin
    mem_addr_c = '0;
    mem_data_c = '0;
    mem_wren_c = 1'b0;
    ready_d    = (state_d == S_IDLE);
    done_d     = (state_d == S_DONE);
    reject_d   = (state_q == S_IDLE) && !bus.clear && bus.start && full_c;
    case (state_q)
      S_RD: begin
        mem_addr_c = i_q[ADDR_WIDTH-1:0];
      end
      S_CMP: begin
        if (shift_c) begin
          mem_addr_c = ADDR_WIDTH'(i_q + CNT_WIDTH'(1));
          mem_data_c = bus.mem_q;
          mem_wren_c = 1'b1;
        end
      end
      S_PUT: begin
        mem_addr_c = i_q[ADDR_WIDTH-1:0];
        mem_data_c = a_q;
        mem_wren_c = 1'b1;
      end
      default: begin
        mem_addr_c = '0;
      end
    endcase
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.reject   = reject_q;
  assign bus.count    = count_q;
  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_data = mem_data_c;
  assign bus.mem_wren = mem_wren_c;

endmodule

// File: tb/tb_sorted_insert_writer.sv
// Directed bench for sorted_insert_writer with a behavioural 32x8 RAM.
module tb_sorted_insert_writer;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  sorted_insert_writer_if #(.VAL_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  sorted_insert_writer #(.VAL_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Single-port RAM: registered address/write, read data valid next cycle.
  logic [7:0] mem [32];
  logic [7:0] q_q = 8'd0;
  int writes  = 0;
  int dones   = 0;
  int rejects = 0;

  always @(posedge clock) begin
    if (bus.mem_wren) begin
      mem[bus.mem_addr] <= bus.mem_data;
      writes <= writes + 1;
    end
    q_q <= mem[bus.mem_addr];
    if (bus.done)   dones   <= dones + 1;
    if (bus.reject) rejects <= rejects + 1;
  end

  assign bus.mem_q = q_q;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns cycles from accepting edge to done (0 if never seen), then
  // advances one more cycle back into idle.
  task automatic do_insert(input logic [7:0] v, output int lat);
    lat = 0;
    bus.start = 1'b1;
    bus.A     = v;
    tick();
    bus.start = 1'b0;
    bus.A     = ~v;
    for (int n = 1; n <= 100; n++) begin
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      tick();
    end
    if (lat != 0) tick();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0, r0, w0;

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.A     = 8'd0;
    for (int k = 0; k < 32; k++) mem[k] = 8'd0;
    #12;
    check("rst_ready",  int'(bus.ready),    1);
    check("rst_done",   int'(bus.done),     0);
    check("rst_reject", int'(bus.reject),   0);
    check("rst_count",  int'(bus.count),    0);
    check("rst_wren",   int'(bus.mem_wren), 0);
    check("rst_addr",   int'(bus.mem_addr), 0);
    check("rst_data",   int'(bus.mem_data), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single insert into empty array.
    do_insert(8'd30, lat);
    check("t1_lat",   lat, 2);
    check("t1_mem0",  int'(mem[0]), 30);
    check("t1_count", int'(bus.count), 1);
    check("t1_ready", int'(bus.ready), 1);

    // 30,10,20,40 -> 10,20,30,40.
    do_clear();
    check("t2_clear", int'(bus.count), 0);
    d0 = dones;
    r0 = rejects;
    do_insert(8'd30, lat); check("t2_lat30", lat, 2);
    do_insert(8'd10, lat); check("t2_lat10", lat, 4);
    do_insert(8'd20, lat); check("t2_lat20", lat, 6);
    do_insert(8'd40, lat); check("t2_lat40", lat, 4);
    check("t2_mem0", int'(mem[0]), 10);
    check("t2_mem1", int'(mem[1]), 20);
    check("t2_mem2", int'(mem[2]), 30);
    check("t2_mem3", int'(mem[3]), 40);
    check("t2_count", int'(bus.count), 4);
    check("t2_dones", dones - d0, 4);
    check("t2_rejects", rejects - r0, 0);

    // Duplicate lands above existing equal value with one shift.
    do_clear();
    do_insert(8'd10, lat);
    do_insert(8'd20, lat);
    do_insert(8'd30, lat);
    w0 = writes;
    do_insert(8'd20, lat);
    check("t3_lat",    lat, 6);
    check("t3_writes", writes - w0, 2);
    check("t3_mem0", int'(mem[0]), 10);
    check("t3_mem1", int'(mem[1]), 20);
    check("t3_mem2", int'(mem[2]), 20);
    check("t3_mem3", int'(mem[3]), 30);
    check("t3_count", int'(bus.count), 4);

    // Clear wins over start.
    d0 = dones;
    r0 = rejects;
    w0 = writes;
    bus.clear = 1'b1;
    bus.start = 1'b1;
    bus.A     = 8'd99;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check("t6_count",  int'(bus.count),  0);
    check("t6_ready",  int'(bus.ready),  1);
    check("t6_reject", int'(bus.reject), 0);
    tick();
    tick();
    check("t6_dones",   dones - d0,   0);
    check("t6_rejects", rejects - r0, 0);
    check("t6_writes",  writes - w0,  0);
    check("t6_ready2",  int'(bus.ready), 1);

    // Worst case: descending fill to capacity.
    for (int v = 31; v >= 0; v--) begin
      do_insert(8'(v), lat);
      check($sformatf("t4_lat_v%0d", v), lat, (v == 31) ? 2 : 2 * (31 - v) + 2);
    end
    for (int k = 0; k < 32; k++) begin
      check($sformatf("t4_mem%0d", k), int'(mem[k]), k);
    end
    check("t4_count", int'(bus.count), 32);

    // Start while full is rejected.
    w0 = writes;
    bus.start = 1'b1;
    bus.A     = 8'd5;
    tick();
    bus.start = 1'b0;
    check("t4_reject",     int'(bus.reject), 1);
    check("t4_rej_ready",  int'(bus.ready),  1);
    check("t4_rej_count",  int'(bus.count),  32);
    tick();
    check("t4_reject_off", int'(bus.reject), 0);
    check("t4_rej_writes", writes - w0, 0);
    check("t4_rej_count2", int'(bus.count), 32);

    // Reset in the middle of an insert into a 10-entry array.
    do_clear();
    for (int v = 0; v < 10; v++) begin
      do_insert(8'(v), lat);
      check($sformatf("t5_fill_lat%0d", v), lat, (v == 0) ? 2 : 4);
    end
    check("t5_count10", int'(bus.count), 10);
    bus.start = 1'b1;
    bus.A     = 8'd5;
    tick();
    bus.start = 1'b0;
    check("t5_rd_ready", int'(bus.ready), 0);
    tick();
    check("t5_cmp_wren", int'(bus.mem_wren), 1);
    check("t5_cmp_addr", int'(bus.mem_addr), 10);
    reset_n = 1'b0;
    #1;
    check("t5_rst_ready",  int'(bus.ready),    1);
    check("t5_rst_done",   int'(bus.done),     0);
    check("t5_rst_reject", int'(bus.reject),   0);
    check("t5_rst_count",  int'(bus.count),    0);
    check("t5_rst_wren",   int'(bus.mem_wren), 0);
    check("t5_rst_addr",   int'(bus.mem_addr), 0);
    check("t5_rst_data",   int'(bus.mem_data), 0);
    #2;
    reset_n = 1'b1;
    tick();
    check("t5_mem10_kept", int'(mem[10]), 10);
    do_insert(8'd7, lat);
    check("t5_lat7",   lat, 2);
    check("t5_mem0",   int'(mem[0]), 7);
    check("t5_count1", int'(bus.count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
